// File: rtl/axis_detector_player.sv
// AXI-Stream event player: takes {timestamp, hit_pattern} words and replays each
// pattern on det_data when the free-running time counter reaches the timestamp.
module axis_detector_player #(
  parameter int WIDTH_BITS = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [WIDTH_BITS-1:0] cfg_width,
  input  logic [127:0]          s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [63:0]           det_data,
  output logic [63:0]           sts_time,
  output logic [31:0]           sts_late
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    PULSE,
    GUARD
  } state_e;

  state_e                state_q;
  logic [63:0]           time_q;
  logic [63:0]           ts_q;
  logic [63:0]           pat_q;
  logic [63:0]           det_q;
  logic [31:0]           late_q;
  logic [WIDTH_BITS-1:0] cnt_q;
  logic                  tready_q;

  logic                  accept;
  logic [WIDTH_BITS-1:0] pulse_last;

  // tready_q is only ever high while in IDLE, so it alone qualifies the handshake.
  assign accept = s_axis_tvalid && tready_q;

  // A zero width is promoted to a single-cycle pulse.
  assign pulse_last = (cfg_width == '0) ? '0 : cfg_width - WIDTH_BITS'(1);

  // NOTE: ts_q/pat_q carry no reset; the state reset already discards any held
  // event, and a reset on wide data registers only costs routing.
  always_ff @(posedge aclk) begin
    if (accept) begin
      ts_q  <= s_axis_tdata[127:64];
      pat_q <= s_axis_tdata[63:0];
    end
  end

  // NOTE: every register here uses non-blocking assignments so that all
  // comparisons in a cycle see the pre-edge values of time_q, cnt_q and state_q.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      time_q   <= '0;
      det_q    <= '0;
      late_q   <= '0;
      cnt_q    <= '0;
      tready_q <= 1'b0;
    end else begin
      time_q <= time_q + 64'd1;
      case (state_q)
        IDLE: begin
          det_q    <= '0;
          tready_q <= 1'b1;
          if (accept) begin
            tready_q <= 1'b0;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (time_q == ts_q) begin
            det_q   <= pat_q;
            cnt_q   <= pulse_last;
            state_q <= PULSE;
          end else if (time_q > ts_q) begin
            // Missed its slot: drop it and return to accepting events.
            if (late_q != '1) begin
              late_q <= late_q + 32'd1;
            end
            tready_q <= 1'b1;
            state_q  <= IDLE;
          end
        end
        PULSE: begin
          if (cnt_q == '0) begin
            det_q   <= '0;
            state_q <= GUARD;
          end else begin
            cnt_q <= cnt_q - WIDTH_BITS'(1);
          end
        end
        GUARD: begin
          det_q    <= '0;
          tready_q <= 1'b1;
          state_q  <= IDLE;
        end
        default: begin
          det_q    <= '0;
          tready_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign s_axis_tready = tready_q;
  assign det_data      = det_q;
  assign sts_time      = time_q;
  assign sts_late      = late_q;

endmodule

// File: doc/axis_detector_player.md
Name: axis_detector_player

Overview:
Transmitter-side counterpart of the detector event path. It consumes 128-bit AXI-Stream event words {timestamp[63:0], hit_pattern[63:0]} and replays each one on a 64-bit detector-style output at the scheduled time on its own free-running time counter. The block is used for stimulus generation, loopback self-test and calibration of the detector acquisition chain. Late events are dropped and counted.

Parameters:
WIDTH_BITS, 8, width of the pulse-length configuration and the internal pulse counter.

Ports:
aclk  in  1  clock
aresetn  in  1  reset, synchronous, active-low
cfg_width  in  WIDTH_BITS  pulse length in aclk cycles; 0 is treated as 1
s_axis_tdata  in  128  [127:64] timestamp, [63:0] hit pattern
s_axis_tvalid  in  1  slave valid
s_axis_tready  out  1  slave ready
det_data  out  64  replayed hit pattern; registered, all-zero when idle
sts_time  out  64  current time counter
sts_late  out  32  count of dropped late events

Behaviour:
- Decided: reset aresetn, synchronous, active-low; clock aclk.
- Reset values: det_data=0, s_axis_tready=0, sts_time=0, sts_late=0, state=IDLE.
- Reset mid-operation discards any held event. det_data is 0 from the next edge.
- Time counter: 64-bit unsigned. It increments by 1 every cycle out of reset. Wrap-around is not handled; 64-bit wrap is out of scope.
- All outputs are registered. s_axis_tready is a decode of the registered state: 1 only in IDLE.
- States:
  - IDLE:
    - tready=1, det_data=0.
    - On tvalid&tready, latch ts_reg and pat_reg, then go to WAIT.
    - The first IDLE cycle after reset release shows tready=1.
  - WAIT:
    - tready=0. Unsigned compare of sts_time against ts_reg each cycle.
    - sts_time==ts_reg: det_data<=pat_reg, cnt<=max(cfg_width,1)-1, go to PULSE.
    - sts_time>ts_reg: event is late. sts_late<=sts_late+1 (saturating at 2^32-1), go to IDLE, det_data stays 0.
    - sts_time<ts_reg: stay in WAIT.
  - PULSE:
    - det_data holds pat_reg.
    - If cnt==0, det_data<=0 and go to GUARD; otherwise cnt<=cnt-1.
    - cfg_width is sampled only on WAIT→PULSE. Changes during a pulse have no effect.
  - GUARD:
    - det_data=0 for exactly 1 cycle, then go to IDLE.
    - Guarantees a zero gap between consecutive events.
- Pulse timing:
  - det_data first goes non-zero in the cycle where sts_time==ts_reg+1.
  - It stays non-zero for exactly max(cfg_width,1) cycles.
- Earliest on-time timestamp: an event accepted in the cycle where sts_time==T is on time iff ts>=T+1. ts<=T counts as late.
- Zero pattern: processed normally (waits, pulse of zeros, guard). Not counted as late.
- Throughput: one event per (wait + width + 2) cycles minimum. Upstream is back-pressured via tready; the held tdata must stay stable per AXI-Stream.
- tvalid with tready=0 has no effect. No data is lost or duplicated.

Test Plan:
1. Reset hold, then release:
   - During reset: det_data=0, tready=0, sts_time=0.
   - Cycle after release: tready=1; sts_time reads 1, 2, 3... on successive cycles.
2. Basic replay: cfg_width=4, send {ts=100, pat=0x0000_0001_0000_0001} at time 10.
   - det_data equals the pattern for exactly 4 cycles (sts_time 101..104), then 0.
   - tready returns to 1 at sts_time 106; sts_late=0.
3. Late event: at sts_time≈50, send ts=5 → no pulse, sts_late=1, tready back to 1 within 2 cycles.
4. Boundary timing, both accepted at sts_time==T:
   - ts=T+1 → fires, first non-zero det_data at sts_time=T+2.
   - ts=T → late, sts_late increments.
5. Width limits:
   - cfg_width=0 → 1-cycle pulse.
   - cfg_width=255 → 255-cycle pulse.
   - cfg_width changed mid-pulse → length unchanged.
6. Back-to-back and reset mid-pulse:
   - Two events with tvalid held high: second is accepted only after GUARD, and both pulses are separated by ≥1 zero cycle.
   - Assert aresetn=0 mid-pulse: det_data=0 next cycle, held event discarded, sts_late=0.
